diffeq_inv: RTL and testbench

Inverse (equalizer) of the team's forward difference-equation filter y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + 0.5y[n-1] + 0.25y[n-2].
- Takes the filtered stream y and reconstructs x: x[n] = y[n] - 0.5y[n-1] - 0.25y[n-2] + x[n-1] - x[n-2] - x[n-3].
- Sits directly after the forward filter in loopback/verification chains, and at the receive end of links that apply the forward filter.
- Sample-enable driven, so it tolerates gaps in the input stream.

---
 rtl/diffeq_inv.sv | 100 ++++++++++
 tb/tb_diffeq_inv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/diffeq_inv.sv
// Inverse of the forward difference-equation filter: rebuilds x[n] from the filtered stream y[n].
// Build option DIFFEQ_INV_SAT_EN: clamp out-of-range results (default build wraps, flag only).
module diffeq_inv #(
    parameter int N     = 16,
    parameter int GUARD = 3
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [N-1:0] i_y,
    output logic [N-1:0] o_x,
    output logic         o_valid,
    output logic         o_primed,
    output logic         o_sat
);
    localparam int A = N + GUARD;

    logic signed [N-1:0] y1, y2, x1, x2, x3;
    logic [1:0]          prime_cnt;

    logic signed [N-1:0] h_y1, h_y2, h_x1, h_x2, h_x3;
    logic [1:0]          h_cnt;
    logic signed [A-1:0] acc;
    logic                ovf_hi, ovf_lo, ovf;
    logic [N-1:0]        x_next;
    logic [1:0]          cnt_next;

    function automatic logic signed [A-1:0] sx(input logic signed [N-1:0] v);
        return {{GUARD{v[N-1]}}, v};
    endfunction

    // A clear in the same cycle as a sample makes that sample see an empty history.
    always_comb begin
        h_y1  = i_clear ? '0 : y1;
        h_y2  = i_clear ? '0 : y2;
        h_x1  = i_clear ? '0 : x1;
        h_x2  = i_clear ? '0 : x2;
        h_x3  = i_clear ? '0 : x3;
        h_cnt = i_clear ? 2'd0 : prime_cnt;
    end

    always_comb begin
        acc = sx(i_y) - sx(h_y1 >>> 1) - sx(h_y2 >>> 2) + sx(h_x1) - sx(h_x2) - sx(h_x3);
        ovf_hi = (acc > sx({1'b0, {(N-1){1'b1}}}));
        ovf_lo = (acc < sx({1'b1, {(N-1){1'b0}}}));
        ovf    = ovf_hi | ovf_lo;
`ifdef DIFFEQ_INV_SAT_EN
        if (ovf_hi)
            x_next = {1'b0, {(N-1){1'b1}}};
        else if (ovf_lo)
            x_next = {1'b1, {(N-1){1'b0}}};
        else
            x_next = acc[N-1:0];
`else
        x_next = acc[N-1:0];
`endif
        cnt_next = (h_cnt == 2'd3) ? 2'd3 : h_cnt + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_x       <= '0;
            o_valid   <= 1'b0;
            o_sat     <= 1'b0;
            y1        <= '0;
            y2        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            prime_cnt <= 2'd0;
        end else begin
            o_valid <= i_valid;
            if (i_clear) begin
                y1        <= '0;
                y2        <= '0;
                x1        <= '0;
                x2        <= '0;
                x3        <= '0;
                prime_cnt <= 2'd0;
                o_sat     <= 1'b0;
            end
            // x history holds the emitted value so feedback matches the output exactly.
            if (i_valid) begin
                o_x       <= x_next;
                y2        <= h_y1;
                y1        <= i_y;
                x3        <= h_x2;
                x2        <= h_x1;
                x1        <= x_next;
                prime_cnt <= cnt_next;
                if (ovf)
                    o_sat <= 1'b1;
            end
        end
    end

    assign o_primed = (prime_cnt == 2'd3);

endmodule

// File: tb/tb_diffeq_inv.sv
// Self-checking bench for diffeq_inv: directed scenarios plus randomized traffic against an integer model.
module tb_diffeq_inv;
    localparam int N    = 16;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic         clk = 1'b0;
    logic         i_rst = 1'b0, i_clear = 1'b0, i_valid = 1'b0;
    logic [N-1:0] i_y = '0;
    logic [N-1:0] o_x;
    logic         o_valid, o_primed, o_sat;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_y1, m_y2, m_x1, m_x2, m_x3, m_cnt, m_sat, m_ox, m_ov;

    diffeq_inv #(.N(N), .GUARD(3)) dut (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .i_y(i_y),
        .o_x(o_x), .o_valid(o_valid), .o_primed(o_primed), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int d);
        if (a < 0 && (a % d) != 0) return a / d - 1;
        return a / d;
    endfunction

    function automatic int wrap16(input int a);
        int r;
        r = (a + 32768) % 65536;
        if (r < 0) r += 65536;
        return r - 32768;
    endfunction

    function automatic void m_step(input bit rst, input bit clr, input bit v, input int y);
        int acc, outv;
        if (rst) begin
            m_y1 = 0; m_y2 = 0; m_x1 = 0; m_x2 = 0; m_x3 = 0;
            m_cnt = 0; m_sat = 0; m_ox = 0; m_ov = 0;
            return;
        end
        m_ov = v;
        if (clr) begin
            m_y1 = 0; m_y2 = 0; m_x1 = 0; m_x2 = 0; m_x3 = 0; m_cnt = 0; m_sat = 0;
        end
        if (v) begin
            acc = y - floor_div(m_y1, 2) - floor_div(m_y2, 4) + m_x1 - m_x2 - m_x3;
            outv = wrap16(acc);
            if (acc > MAXV || acc < MINV) begin
                m_sat = 1;
`ifdef DIFFEQ_INV_SAT_EN
                outv = (acc > MAXV) ? MAXV : MINV;
`endif
            end
            m_y2 = m_y1; m_y1 = y;
            m_x3 = m_x2; m_x2 = m_x1; m_x1 = outv;
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            m_ox = outv;
        end
    endfunction

    task automatic drive(input bit rst, input bit clr, input bit v, input int y);
        i_rst = rst; i_clear = clr; i_valid = v; i_y = N'(y);
        @(posedge clk);
        #1;
        m_step(rst, clr, v, y);
        i_rst = 1'b0; i_clear = 1'b0; i_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 1234);
        drive(1, 0, 0, 0);
        n_tests++;
        if ({o_x, o_valid, o_primed, o_sat} !== {16'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got x=%0d v=%0b p=%0b s=%0b expected all zero",
                     $signed(o_x), o_valid, o_primed, o_sat);
        end
    endtask

    task automatic test_impulse();
        int ys[4] = '{100, -50, 100, 0};
        int xs[3] = '{100, 0, 0};
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, ys[i]);
            n_tests++;
            if (o_valid !== 1'b1 || $signed(o_x) !== m_ox || o_primed !== (i >= 2)) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got x=%0d v=%0b p=%0b expected x=%0d v=1 p=%0b",
                         i, $signed(o_x), o_valid, o_primed, m_ox, (i >= 2));
            end
            if (i < 3) begin
                n_tests++;
                if ($signed(o_x) !== xs[i]) begin
                    n_fail++;
                    $display("FAIL impulse_const[%0d]: got %0d expected %0d", i, $signed(o_x), xs[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int ys[4] = '{100, -50, 100, 0};
        drive(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, ys[i]);
            n_tests++;
            if (o_valid !== 1'b1 || $signed(o_x) !== m_ox) begin
                n_fail++;
                $display("FAIL gaps_sample[%0d]: got x=%0d v=%0b expected x=%0d v=1",
                         i, $signed(o_x), o_valid, m_ox);
            end
            for (int g = 0; g < 2; g++) begin
                drive(0, 0, 0, 555);
                n_tests++;
                if (o_valid !== 1'b0 || $signed(o_x) !== m_ox || o_primed !== (i >= 2)) begin
                    n_fail++;
                    $display("FAIL gaps_hold[%0d.%0d]: got x=%0d v=%0b p=%0b expected x=%0d v=0",
                             i, g, $signed(o_x), o_valid, o_primed, m_ox);
                end
            end
        end
    endtask

    task automatic test_saturation();
`ifdef DIFFEQ_INV_SAT_EN
        int exp2 = 32767;
`else
        int exp2 = -16385;
`endif
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 32767);
        n_tests++;
        if ($signed(o_x) !== 32767 || o_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_first: got x=%0d s=%0b expected x=32767 s=0", $signed(o_x), o_sat);
        end
        drive(0, 0, 1, 32767);
        n_tests++;
        if ($signed(o_x) !== exp2 || o_sat !== 1'b1 || m_ox !== exp2) begin
            n_fail++;
            $display("FAIL sat_second: got x=%0d s=%0b expected x=%0d s=1", $signed(o_x), o_sat, exp2);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            n_tests++;
            if (o_sat !== 1'b1 || $signed(o_x) !== m_ox) begin
                n_fail++;
                $display("FAIL sat_sticky[%0d]: got x=%0d s=%0b expected x=%0d s=1",
                         i, $signed(o_x), o_sat, m_ox);
            end
        end
    endtask

    task automatic test_clear_collision();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 32767);
        drive(0, 0, 1, 32767);
        drive(0, 0, 1, 100);
        drive(0, 0, 1, -50);
        drive(0, 1, 1, 40);
        n_tests++;
        if ($signed(o_x) !== 40 || o_valid !== 1'b1 || o_primed !== 1'b0 || o_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_collision: got x=%0d v=%0b p=%0b s=%0b expected x=40 v=1 p=0 s=0",
                     $signed(o_x), o_valid, o_primed, o_sat);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 10 * (i + 1));
            n_tests++;
            if (o_primed !== (i == 1) || $signed(o_x) !== m_ox) begin
                n_fail++;
                $display("FAIL clear_reprime[%0d]: got x=%0d p=%0b expected x=%0d p=%0b",
                         i, $signed(o_x), o_primed, m_ox, (i == 1));
            end
        end
        drive(0, 1, 0, 0);
        n_tests++;
        if ($signed(o_x) !== m_ox || o_valid !== 1'b0 || o_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_only: got x=%0d v=%0b p=%0b expected x=%0d v=0 p=0",
                     $signed(o_x), o_valid, o_primed, m_ox);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 300);
        drive(0, 0, 1, 200);
        drive(0, 0, 1, -900);
        drive(1, 0, 1, 77);
        n_tests++;
        if ({o_x, o_valid, o_primed, o_sat} !== {16'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid: got x=%0d v=%0b p=%0b s=%0b expected all zero",
                     $signed(o_x), o_valid, o_primed, o_sat);
        end
        drive(0, 0, 1, 7);
        n_tests++;
        if ($signed(o_x) !== 7 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_next: got x=%0d v=%0b expected x=7 v=1", $signed(o_x), o_valid);
        end
    endtask

    task automatic test_random();
        bit rst, clr, v;
        int y;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                y = int'($urandom_range(0, 65535)) - 32768;
            else
                y = int'($urandom_range(0, 800)) - 400;
            drive(rst, clr, v, y);
            n_tests++;
            if ($signed(o_x) !== m_ox || o_valid !== m_ov[0] || o_primed !== (m_cnt == 3)
                || o_sat !== m_sat[0]) begin
                n_fail++;
                $display("FAIL random[%0d]: got x=%0d v=%0b p=%0b s=%0b expected x=%0d v=%0d p=%0b s=%0d",
                         i, $signed(o_x), o_valid, o_primed, o_sat, m_ox, m_ov, (m_cnt == 3), m_sat);
            end
        end
    endtask

    initial begin
        m_step(1, 0, 0, 0);
        test_reset();
        test_impulse();
        test_gaps();
        test_saturation();
        test_clear_collision();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
